// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: datapath width, fetch FSM
// state encoding, fault cause codes and a small alignment helper.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_TIMEOUT  = 2'd2
  } fault_cause_t;

  // Instruction addresses must sit on a 32-bit word boundary.
  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read port: a single outstanding request held
// until a one-cycle acknowledge returns the data word.
interface instr_fetch_if;
  import core_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ack;

  // Fetch stage side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  // Memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/fetch_timeout_cnt.sv
// Loadable up-counter that flags the last permitted wait cycle of an
// outstanding memory request.
module fetch_timeout_cnt #(
  parameter int W    = 8,
  parameter int TERM = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic         terminal
);

  logic [W-1:0] count_reg;

  // Load has priority so the count restarts cleanly on each new request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // The count holds TERM-1 during the TERM-th cycle without ack.
  assign terminal = (count_reg == W'(TERM - 1));

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle fetch stage: samples the PC, requests the word from
// instruction memory, and holds it in the IR until control retires it.
// Stops for good on end-of-program, a misaligned PC or a memory timeout.
module instr_fetch
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    pc_addr,
  input  logic               pc_eof,
  instr_fetch_if.master      imem,
  output logic [XLEN-1:0]    ir,
  output logic [XLEN-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_consume,
  output logic               done,
  output logic               fault,
  output logic [1:0]         fault_cause,
  output logic [CNT_W-1:0]   fetch_cnt
);

  fetch_state_t    state_reg, state_next;
  logic            req_reg, req_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [XLEN-1:0] ir_reg, ir_next;
  logic [XLEN-1:0] ir_pc_reg, ir_pc_next;
  logic            valid_reg, valid_next;
  logic            done_reg, done_next;
  logic            fault_reg, fault_next;
  fault_cause_t    cause_reg, cause_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic tmo_load;
  logic tmo_inc;
  logic tmo_terminal;

  fetch_timeout_cnt #(
    .W    (8),
    .TERM (MAX_WAIT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .load_val (8'd0),
    .inc      (tmo_inc),
    .terminal (tmo_terminal)
  );

  // State and every output register; reset drops an in-flight request at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      addr_reg  <= '0;
      ir_reg    <= '0;
      ir_pc_reg <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      fault_reg <= 1'b0;
      cause_reg <= FC_NONE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
      ir_reg    <= ir_next;
      ir_pc_reg <= ir_pc_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      fault_reg <= fault_next;
      cause_reg <= cause_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and next-output decode; everything holds unless changed.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    ir_next    = ir_reg;
    ir_pc_next = ir_pc_reg;
    valid_next = valid_reg;
    done_next  = done_reg;
    fault_next = fault_reg;
    cause_next = cause_reg;
    cnt_next   = cnt_reg;
    tmo_load   = 1'b0;
    tmo_inc    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pc_eof) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else if (!is_word_aligned(pc_addr)) begin
          state_next = FAULT;
          fault_next = 1'b1;
          cause_next = FC_MISALIGN;
        end else begin
          state_next = REQ;
          req_next   = 1'b1;
          addr_next  = pc_addr;
          tmo_load   = 1'b1;
        end
      end
      REQ: begin
        // An ack on the final wait cycle still wins over the timeout.
        if (imem.imem_ack) begin
          state_next = HOLD;
          req_next   = 1'b0;
          ir_next    = imem.imem_rdata;
          ir_pc_next = addr_reg;
          valid_next = 1'b1;
          if (cnt_reg != '1) begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (tmo_terminal) begin
          state_next = FAULT;
          req_next   = 1'b0;
          fault_next = 1'b1;
          cause_next = FC_TIMEOUT;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      HOLD: begin
        if (ir_consume) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
      end
      DONE, FAULT: begin
        req_next = 1'b0;
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  assign imem.imem_req  = req_reg;
  assign imem.imem_addr = addr_reg;
  assign ir             = ir_reg;
  assign ir_pc          = ir_pc_reg;
  assign ir_valid       = valid_reg;
  assign done           = done_reg;
  assign fault          = fault_reg;
  assign fault_cause    = cause_reg;
  assign fetch_cnt      = cnt_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: basic fetch, wait states, end of
// program, timeout, misaligned PC and asynchronous reset mid-request.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_eof;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_consume;
  logic        done;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [15:0] fetch_cnt;

  int vectors;
  int miscompares;

  instr_fetch_if imem_bus ();

  instr_fetch #(
    .MAX_WAIT (15),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .pc_eof      (pc_eof),
    .imem        (imem_bus),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_consume  (ir_consume),
    .done        (done),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".req"},   {31'd0, imem_bus.imem_req}, 32'd0);
    check({tag, ".addr"},  imem_bus.imem_addr, 32'd0);
    check({tag, ".ir"},    ir, 32'd0);
    check({tag, ".ir_pc"}, ir_pc, 32'd0);
    check({tag, ".valid"}, {31'd0, ir_valid}, 32'd0);
    check({tag, ".done"},  {31'd0, done}, 32'd0);
    check({tag, ".fault"}, {31'd0, fault}, 32'd0);
    check({tag, ".cause"}, {30'd0, fault_cause}, 32'd0);
    check({tag, ".cnt"},   {16'd0, fetch_cnt}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    pc_addr     = 32'h0;
    pc_eof      = 1'b0;
    ir_consume  = 1'b0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;

    // ---- reset state
    step();
    step();
    check_reset_values("reset");
    $display("reset: outputs at reset values");

    // ---- basic fetch from 0x0, ack in first REQ cycle
    rst = 1'b1;
    step();                                   // IDLE -> REQ
    check("basic.req",   {31'd0, imem_bus.imem_req}, 32'd1);
    check("basic.addr",  imem_bus.imem_addr, 32'h0);
    check("basic.valid_early", {31'd0, ir_valid}, 32'd0);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h0000_0093;
    step();                                   // REQ -> HOLD
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    check("basic.valid", {31'd0, ir_valid}, 32'd1);
    check("basic.ir",    ir, 32'h0000_0093);
    check("basic.ir_pc", ir_pc, 32'h0);
    check("basic.cnt",   {16'd0, fetch_cnt}, 32'd1);
    check("basic.req_drop", {31'd0, imem_bus.imem_req}, 32'd0);
    step();                                   // HOLD dwell, IR stable
    check("basic.hold_ir", ir, 32'h0000_0093);
    check("basic.hold_valid", {31'd0, ir_valid}, 32'd1);
    ir_consume = 1'b1;
    pc_addr    = 32'h4;
    step();                                   // HOLD -> IDLE
    ir_consume = 1'b0;
    check("basic.consumed", {31'd0, ir_valid}, 32'd0);
    check("basic.ir_kept",  ir, 32'h0000_0093);
    check("basic.idle_req", {31'd0, imem_bus.imem_req}, 32'd0);
    step();                                   // IDLE -> REQ at 0x4
    check("basic.next_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("basic.next_addr", imem_bus.imem_addr, 32'h4);
    $display("basic: fetched 0x00000093 from 0x0, next request at 0x4");

    // ---- wait states: ack arrives in the 6th REQ cycle
    for (int i = 0; i < 5; i++) begin
      step();
      check("wait.req",   {31'd0, imem_bus.imem_req}, 32'd1);
      check("wait.addr",  imem_bus.imem_addr, 32'h4);
      check("wait.fault", {31'd0, fault}, 32'd0);
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h0010_0113;
    step();
    imem_bus.imem_ack   = 1'b0;
    check("wait.valid", {31'd0, ir_valid}, 32'd1);
    check("wait.ir",    ir, 32'h0010_0113);
    check("wait.ir_pc", ir_pc, 32'h4);
    check("wait.cnt",   {16'd0, fetch_cnt}, 32'd2);
    check("wait.req_drop", {31'd0, imem_bus.imem_req}, 32'd0);
    $display("wait: 6-cycle request at 0x4 latched 0x00100113");

    // ---- third instruction, then end of program seen at next IDLE
    ir_consume = 1'b1;
    pc_addr    = 32'h8;
    step();
    ir_consume = 1'b0;
    step();
    check("third.addr", imem_bus.imem_addr, 32'h8);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h0020_0193;
    step();
    imem_bus.imem_ack   = 1'b0;
    check("third.ir",  ir, 32'h0020_0193);
    check("third.cnt", {16'd0, fetch_cnt}, 32'd3);
    pc_eof = 1'b1;                            // raised while in HOLD
    step();
    check("eof.hold_done", {31'd0, done}, 32'd0);
    ir_consume = 1'b1;
    pc_addr    = 32'hC;
    step();                                   // HOLD -> IDLE
    ir_consume = 1'b0;
    step();                                   // IDLE -> DONE
    check("eof.done", {31'd0, done}, 32'd1);
    check("eof.cnt",  {16'd0, fetch_cnt}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("eof.no_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check("eof.sticky", {31'd0, done}, 32'd1);
    end
    $display("eof: done after 3 fetches");

    // ---- timeout after exactly 15 REQ cycles
    #2 rst = 1'b0;
    #1 check("tmo.async_done", {31'd0, done}, 32'd0);
    step();
    rst     = 1'b1;
    pc_eof  = 1'b0;
    pc_addr = 32'h10;
    step();                                   // REQ cycle 1
    check("tmo.req", {31'd0, imem_bus.imem_req}, 32'd1);
    for (int i = 0; i < 14; i++) begin
      step();                                 // REQ cycles 2..15
      check("tmo.pending_fault", {31'd0, fault}, 32'd0);
      check("tmo.pending_req",   {31'd0, imem_bus.imem_req}, 32'd1);
    end
    step();
    check("tmo.fault", {31'd0, fault}, 32'd1);
    check("tmo.cause", {30'd0, fault_cause}, 32'd2);
    check("tmo.req_drop", {31'd0, imem_bus.imem_req}, 32'd0);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h1234_5678;
    ir_consume          = 1'b1;
    step();
    step();
    imem_bus.imem_ack = 1'b0;
    ir_consume        = 1'b0;
    check("tmo.sticky",  {31'd0, fault}, 32'd1);
    check("tmo.cause2",  {30'd0, fault_cause}, 32'd2);
    check("tmo.no_valid", {31'd0, ir_valid}, 32'd0);
    check("tmo.cnt",     {16'd0, fetch_cnt}, 32'd0);
    check("tmo.ir",      ir, 32'd0);
    check("tmo.no_req",  {31'd0, imem_bus.imem_req}, 32'd0);
    $display("timeout: fault cause 2 after 15 request cycles");

    // ---- misaligned PC
    rst = 1'b0;
    step();
    rst     = 1'b1;
    pc_addr = 32'h6;
    step();
    check("mis.fault", {31'd0, fault}, 32'd1);
    check("mis.cause", {30'd0, fault_cause}, 32'd1);
    check("mis.req",   {31'd0, imem_bus.imem_req}, 32'd0);
    pc_addr = 32'h8;
    for (int i = 0; i < 2; i++) begin
      step();
      check("mis.no_req", {31'd0, imem_bus.imem_req}, 32'd0);
    end
    $display("misaligned: fault cause 1 at pc 0x6");

    // ---- asynchronous reset during REQ
    rst = 1'b0;
    step();
    rst     = 1'b1;
    pc_addr = 32'h20;
    step();
    check("arst.req", {31'd0, imem_bus.imem_req}, 32'd1);
    step();
    step();
    #2 rst = 1'b0;
    #1 check_reset_values("arst");
    step();
    rst = 1'b1;
    step();
    check("arst.restart_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("arst.restart_addr", imem_bus.imem_addr, 32'h20);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h0030_0213;
    step();
    imem_bus.imem_ack = 1'b0;
    check("arst.ir",    ir, 32'h0030_0213);
    check("arst.ir_pc", ir_pc, 32'h20);
    check("arst.cnt",   {16'd0, fetch_cnt}, 32'd1);
    $display("async reset: request dropped, fetch restarted at 0x20");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
